reg_scoreboard: RTL and testbench

- Read-side companion to the CPU register file.
- Tracks, per architectural register, how many issued instructions still owe a write to it.
- Gives the decode stage a stall decision for RAW hazards and for dest-counter saturation.
- Retirement is driven by the same write-enable and write-address that feed the register file write port. Because the register file writes on negedge, a value retiring in cycle N is readable in decode in cycle N, so retire is bypassed.

---
 rtl/reg_scoreboard_pkg.sv | 10 +
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/reg_scoreboard_sb_counter.sv | 42 ++++
 rtl/reg_scoreboard.sv | 92 +++++++++
 tb/tb_reg_scoreboard.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU constants and types used by the register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned SB_CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode, writeback and kill signals between the pipeline and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                     issue_valid;
  reg_addr_t                src_a;
  logic                     src_a_used;
  reg_addr_t                src_b;
  logic                     src_b_used;
  logic                     dest_valid;
  reg_addr_t                dest_addr;
  logic                     stall;
  logic                     issue_fire;
  logic                     retire_en;
  reg_addr_t                retire_addr;
  logic                     kill_en;
  reg_addr_t                kill_addr;
  logic [NUM_ARCH_REGS-1:0] busy_mask;
  logic                     err_underflow;
  logic                     err_overflow;
  logic                     err_clear;

  modport master (
    output issue_valid, src_a, src_a_used, src_b, src_b_used, dest_valid, dest_addr,
    output retire_en, retire_addr, kill_en, kill_addr, err_clear,
    input  stall, issue_fire, busy_mask, err_underflow, err_overflow
  );

  modport slave (
    input  issue_valid, src_a, src_a_used, src_b, src_b_used, dest_valid, dest_addr,
    input  retire_en, retire_addr, kill_en, kill_addr, err_clear,
    output stall, issue_fire, busy_mask, err_underflow, err_overflow
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating pending-write counter: +inc, -dec (0..2), with clamp error pulses.
module reg_scoreboard_sb_counter #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic [1:0]      dec_i,
  output logic [CntW-1:0] count_o,
  output logic            underflow_o,
  output logic            overflow_o
);

  localparam logic signed [CntW+1:0] MaxS = {2'b00, {CntW{1'b1}}};

  logic [CntW-1:0]        count_q, count_d;
  logic signed [CntW+1:0] sum;

  always_comb begin
    sum = $signed({2'b00, count_q}) + $signed({{(CntW+1){1'b0}}, inc_i})
          - $signed({{CntW{1'b0}}, dec_i});
    underflow_o = sum < 0;
    overflow_o  = sum > MaxS;
    count_d     = sum[CntW-1:0];
    if (underflow_o) begin
      count_d = '0;
    end else if (overflow_o) begin
      count_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard; stalls decode on RAW hazards and full counters.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CntW  = SB_CNT_W,
  parameter int unsigned NRegs = NUM_ARCH_REGS
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_scoreboard_if.slave sb
);

  localparam logic [CntW-1:0] CntMax = '1;

  logic [CntW-1:0]  count [NRegs];
  logic [CntW-1:0]  eff   [NRegs];
  logic [NRegs-1:0] uf, of;
  logic             src_hazard, dest_full, stall, issue_fire;
  logic             err_underflow_q, err_underflow_d;
  logic             err_overflow_q, err_overflow_d;

  for (genvar r = 0; r < NRegs; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign count[r] = '0;
      assign eff[r]   = '0;
      assign uf[r]    = 1'b0;
      assign of[r]    = 1'b0;
    end else begin : g_track
      logic       ret_hit, kill_hit, inc;
      logic [1:0] rel;

      assign ret_hit  = sb.retire_en && (sb.retire_addr == reg_addr_t'(r));
      assign kill_hit = sb.kill_en && (sb.kill_addr == reg_addr_t'(r));
      assign rel      = {1'b0, ret_hit} + {1'b0, kill_hit};
      assign inc      = issue_fire && sb.dest_valid && (sb.dest_addr == reg_addr_t'(r));
      // Retire is bypassed: a write landing this cycle is already readable.
      assign eff[r]   = ({2'b00, count[r]} > {{CntW{1'b0}}, rel}) ?
                        count[r] - CntW'(rel) : '0;

      reg_scoreboard_sb_counter #(
        .CntW (CntW)
      ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc),
        .dec_i       (rel),
        .count_o     (count[r]),
        .underflow_o (uf[r]),
        .overflow_o  (of[r])
      );
    end
  end

  for (genvar i = 0; i < NUM_ARCH_REGS; i++) begin : g_busy
    if (i < NRegs) begin : g_live
      assign sb.busy_mask[i] = |count[i];
    end else begin : g_none
      assign sb.busy_mask[i] = 1'b0;
    end
  end

  always_comb begin
    src_hazard = (sb.src_a_used && (eff[sb.src_a] != '0)) ||
                 (sb.src_b_used && (eff[sb.src_b] != '0));
    dest_full  = sb.dest_valid && (sb.dest_addr != '0) && (eff[sb.dest_addr] == CntMax);
    stall      = sb.issue_valid && (src_hazard || dest_full);
    issue_fire = sb.issue_valid && !stall;
  end

  assign sb.stall      = stall;
  assign sb.issue_fire = issue_fire;

  // A new error in the clearing cycle wins over the clear.
  always_comb begin
    err_underflow_d = (err_underflow_q && !sb.err_clear) || (|uf);
    err_overflow_d  = (err_overflow_q && !sb.err_clear) || (|of);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign sb.err_underflow = err_underflow_q;
  assign sb.err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    sb_if.issue_valid = 1'b0;
    sb_if.src_a       = '0;
    sb_if.src_a_used  = 1'b0;
    sb_if.src_b       = '0;
    sb_if.src_b_used  = 1'b0;
    sb_if.dest_valid  = 1'b0;
    sb_if.dest_addr   = '0;
    sb_if.retire_en   = 1'b0;
    sb_if.retire_addr = '0;
    sb_if.kill_en     = 1'b0;
    sb_if.kill_addr   = '0;
    sb_if.err_clear   = 1'b0;
  endtask

  task automatic issue(input reg_addr_t dest);
    drive_idle();
    sb_if.issue_valid = 1'b1;
    sb_if.dest_valid  = 1'b1;
    sb_if.dest_addr   = dest;
  endtask

  task automatic retire(input reg_addr_t a);
    drive_idle();
    sb_if.retire_en   = 1'b1;
    sb_if.retire_addr = a;
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_idle();
    #3;
    check("rst_busy", sb_if.busy_mask, 32'h0);
    check("rst_uf", {31'b0, sb_if.err_underflow}, 32'd0);
    check("rst_of", {31'b0, sb_if.err_overflow}, 32'd0);
    check("rst_stall", {31'b0, sb_if.stall}, 32'd0);
    check("rst_fire", {31'b0, sb_if.issue_fire}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic RAW on r5 with same-cycle retire bypass
    issue(5'd5);
    #1 check("raw_issue_fire", {31'b0, sb_if.issue_fire}, 32'd1);
    tick();
    check("raw_busy5", sb_if.busy_mask, 32'h0000_0020);
    drive_idle();
    sb_if.issue_valid = 1'b1;
    sb_if.src_a       = 5'd5;
    sb_if.src_a_used  = 1'b1;
    #1 check("raw_stall", {31'b0, sb_if.stall}, 32'd1);
    check("raw_nofire", {31'b0, sb_if.issue_fire}, 32'd0);
    sb_if.retire_en   = 1'b1;
    sb_if.retire_addr = 5'd5;
    #1 check("raw_bypass_stall", {31'b0, sb_if.stall}, 32'd0);
    check("raw_bypass_fire", {31'b0, sb_if.issue_fire}, 32'd1);
    tick();
    drive_idle();
    check("raw_busy_clear", sb_if.busy_mask, 32'h0);

    // srcB hazard path
    issue(5'd6);
    tick();
    drive_idle();
    sb_if.issue_valid = 1'b1;
    sb_if.src_b       = 5'd6;
    sb_if.src_b_used  = 1'b1;
    #1 check("srcb_stall", {31'b0, sb_if.stall}, 32'd1);
    sb_if.src_b_used  = 1'b0;
    #1 check("srcb_unused", {31'b0, sb_if.stall}, 32'd0);
    retire(5'd6);
    tick();

    // Saturation on r7
    for (int i = 0; i < 3; i++) begin
      issue(5'd7);
      #1 check($sformatf("sat_fire%0d", i), {31'b0, sb_if.issue_fire}, 32'd1);
      tick();
    end
    check("sat_busy7", sb_if.busy_mask, 32'h0000_0080);
    issue(5'd7);
    #1 check("sat_full_stall", {31'b0, sb_if.stall}, 32'd1);
    sb_if.retire_en   = 1'b1;
    sb_if.retire_addr = 5'd7;
    #1 check("sat_retire_fire", {31'b0, sb_if.issue_fire}, 32'd1);
    tick();
    issue(5'd7);
    #1 check("sat_still_full", {31'b0, sb_if.stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      retire(5'd7);
      tick();
    end
    drive_idle();
    check("sat_drained", sb_if.busy_mask, 32'h0);
    check("sat_no_uf", {31'b0, sb_if.err_underflow}, 32'd0);
    check("sat_no_of", {31'b0, sb_if.err_overflow}, 32'd0);

    // Kill plus retire on r9 in one cycle
    issue(5'd9);
    tick();
    issue(5'd9);
    tick();
    check("kr_busy9", sb_if.busy_mask, 32'h0000_0200);
    retire(5'd9);
    sb_if.kill_en   = 1'b1;
    sb_if.kill_addr = 5'd9;
    tick();
    drive_idle();
    check("kr_busy_clear", sb_if.busy_mask, 32'h0);
    check("kr_no_uf", {31'b0, sb_if.err_underflow}, 32'd0);

    // Register 0 is never tracked
    for (int i = 0; i < 3; i++) begin
      issue(5'd0);
      sb_if.src_a       = 5'd0;
      sb_if.src_a_used  = 1'b1;
      sb_if.retire_en   = 1'b1;
      sb_if.retire_addr = 5'd0;
      sb_if.kill_en     = 1'b1;
      sb_if.kill_addr   = 5'd0;
      #1 check($sformatf("r0_stall%0d", i), {31'b0, sb_if.stall}, 32'd0);
      tick();
    end
    drive_idle();
    check("r0_busy", sb_if.busy_mask, 32'h0);
    check("r0_no_uf", {31'b0, sb_if.err_underflow}, 32'd0);

    // Underflow on r12, sticky, clear, and clear losing to a new error
    retire(5'd12);
    tick();
    drive_idle();
    check("uf_set", {31'b0, sb_if.err_underflow}, 32'd1);
    check("uf_busy", sb_if.busy_mask, 32'h0);
    tick();
    check("uf_sticky", {31'b0, sb_if.err_underflow}, 32'd1);
    retire(5'd12);
    sb_if.err_clear = 1'b1;
    tick();
    check("uf_new_wins", {31'b0, sb_if.err_underflow}, 32'd1);
    drive_idle();
    sb_if.err_clear = 1'b1;
    tick();
    drive_idle();
    check("uf_cleared", {31'b0, sb_if.err_underflow}, 32'd0);

    // Async reset mid-flight
    issue(5'd3);
    tick();
    issue(5'd4);
    tick();
    issue(5'd31);
    tick();
    drive_idle();
    check("ar_busy", sb_if.busy_mask, 32'h8000_0018);
    sb_if.issue_valid = 1'b1;
    sb_if.src_a       = 5'd3;
    sb_if.src_a_used  = 1'b1;
    #1 check("ar_pre_stall", {31'b0, sb_if.stall}, 32'd1);
    rst_n = 1'b0;
    #1 check("ar_busy_zero", sb_if.busy_mask, 32'h0);
    check("ar_stall_zero", {31'b0, sb_if.stall}, 32'd0);
    check("ar_fire", {31'b0, sb_if.issue_fire}, 32'd1);
    #1 rst_n = 1'b1;
    drive_idle();
    tick();
    check("ar_after", sb_if.busy_mask, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
